// File: rtl/pipelined_mdu_alu.sv
// Clocked MIPS R-type ALU with an iterative multiply/divide unit and HI/LO.
// Define ALU_OVERFLOW_TRAP_EN to add the signed add/sub overflow flag (ovf).
module pipelined_mdu_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef ALU_OVERFLOW_TRAP_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULU = 6'h19;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic {S_IDLE, S_ITER} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_valid;

  logic             w_acc;
  logic             w_multi;
  logic             w_is_div;
  logic             w_dz;
  logic             w_sgn;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_ovf;

  assign w_acc    = in_valid && (r_state == S_IDLE);
  assign w_is_div = (funct == F_DIV) || (funct == F_DIVU);
  assign w_multi  = w_is_div || (funct == F_MULT) || (funct == F_MULU);
  assign w_dz     = w_is_div && (inp2 == '0);
  assign w_sgn    = (funct == F_MULT) || (funct == F_DIV);
  assign w_a_neg  = w_sgn && inp1[WIDTH-1];
  assign w_b_neg  = w_sgn && inp2[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -inp1 : inp1;
  assign w_b_mag  = w_b_neg ? -inp2 : inp2;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign out       = r_out;
  assign hi        = r_hi;
  assign lo        = r_lo;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc && w_multi && !w_dz) w_state_nxt = S_ITER;
      S_ITER: if (r_cnt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One shift-add (mult) or restoring-subtract (div) step on magnitudes
  logic [WIDTH:0]     w_msum;
  logic [WIDTH:0]     w_dsh;
  logic [WIDTH:0]     w_dsub;
  logic [WIDTH-1:0]   w_rem_nx;
  logic [WIDTH-1:0]   w_q_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_fhi;
  logic [WIDTH-1:0]   w_flo;

  always_comb begin
    w_msum   = {1'b0, r_rem} + {1'b0, r_b & {WIDTH{r_q[0]}}};
    w_dsh    = {r_rem, r_q[WIDTH-1]};
    w_dsub   = w_dsh - {1'b0, r_b};
    w_rem_nx = w_msum[WIDTH:1];
    w_q_nx   = {w_msum[0], r_q[WIDTH-1:1]};
    if (r_div) begin
      if (w_dsh >= {1'b0, r_b}) begin
        w_rem_nx = w_dsub[WIDTH-1:0];
        w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_rem_nx = w_dsh[WIDTH-1:0];
        w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
      end
    end
    w_prod   = {w_rem_nx, w_q_nx};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_fhi    = w_prod_s[2*WIDTH-1:WIDTH];
    w_flo    = w_prod_s[WIDTH-1:0];
    if (r_div) begin
      w_flo = r_neg_q ? -w_q_nx : w_q_nx;
      w_fhi = r_neg_r ? -w_rem_nx : w_rem_nx;
    end
  end

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;

  always_comb begin
    w_sum = inp1 + inp2;
    w_dif = inp1 - inp2;
    w_res = '0;
    case (funct)
      F_SLL:         w_res = inp2 << shamt;
      F_SRL:         w_res = inp2 >> shamt;
      F_SRA:         w_res = $signed(inp2) >>> shamt;
      F_ADD, F_ADDU: w_res = w_sum;
      F_SUB:         w_res = w_dif;
      F_AND:         w_res = inp1 & inp2;
      F_OR:          w_res = inp1 | inp2;
      F_SLTU:        w_res = {{(WIDTH-1){1'b0}}, inp1 < inp2};
      F_MFHI:        w_res = r_hi;
      F_MFLO:        w_res = r_lo;
      default:       w_res = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_TRAP_EN
  logic r_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (funct == F_ADD)
      w_ovf = (inp1[WIDTH-1] == inp2[WIDTH-1]) &&
              (w_sum[WIDTH-1] != inp1[WIDTH-1]);
    else if (funct == F_SUB)
      w_ovf = (inp1[WIDTH-1] != inp2[WIDTH-1]) &&
              (w_dif[WIDTH-1] != inp1[WIDTH-1]);
  end

  // Flag tracks each result; only a single-cycle add/sub can raise it
  always_ff @(posedge clk) begin
    if (reset)
      r_ovf <= 1'b0;
    else if (r_state == S_ITER && r_cnt == '0)
      r_ovf <= 1'b0;
    else if (w_acc)
      r_ovf <= w_ovf && !w_multi;
  end

  assign ovf = r_ovf;
`else
  assign w_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_out   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_ITER) begin
        r_rem <= w_rem_nx;
        r_q   <= w_q_nx;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_hi    <= w_fhi;
          r_lo    <= w_flo;
          r_out   <= w_flo;
          r_valid <= 1'b1;
        end
      end else if (w_acc) begin
        if (w_dz) begin
          r_lo    <= '1;
          r_hi    <= inp1;
          r_out   <= '1;
          r_valid <= 1'b1;
        end else if (w_multi) begin
          r_q     <= w_a_mag;
          r_b     <= w_b_mag;
          r_rem   <= '0;
          r_div   <= w_is_div;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= SHW'(WIDTH - 1);
        end else begin
          r_valid <= 1'b1;
          if (!w_ovf) r_out <= w_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_mdu_alu.sv
// Scoreboard bench for pipelined_mdu_alu (WIDTH=32).
// Build with ALU_OVERFLOW_TRAP_EN to also check the ovf flag.
module tb_pipelined_mdu_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   funct = '0;
  logic [W-1:0] inp1 = '0;
  logic [W-1:0] inp2 = '0;
  logic [4:0]   shamt = '0;
  logic         out_valid;
  logic [W-1:0] out;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
`ifdef ALU_OVERFLOW_TRAP_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  logic [W-1:0] q_out[$];
  logic [W-1:0] q_hi[$];
  logic [W-1:0] q_lo[$];
  logic         q_ovf[$];
  string        q_nm[$];

  logic [W-1:0] e_o;
  logic [W-1:0] e_h;
  logic [W-1:0] e_l;
  logic         e_v;
  string        e_n;

  pipelined_mdu_alu #(.WIDTH(W)) dut (
`ifdef ALU_OVERFLOW_TRAP_EN
    .ovf(ovf),
`endif
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .funct(funct),
    .inp1(inp1),
    .inp2(inp2),
    .shamt(shamt),
    .out_valid(out_valid),
    .out(out),
    .hi(hi),
    .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference model: computes the expected result and pushes it
  task automatic expect_op(input string nm, input logic [5:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] sh);
    logic [W-1:0]   o;
    logic [2*W-1:0] p;
    logic           v;
    longint         sa;
    longint         sb;
    o = '0;
    v = 1'b0;
    sa = $signed(a);
    sb = $signed(b);
    case (f)
      6'h00: o = b << sh;
      6'h02: o = b >> sh;
      6'h03: o = $signed(b) >>> sh;
      6'h20: begin
        o = a + b;
`ifdef ALU_OVERFLOW_TRAP_EN
        if ((sa + sb) > 64'sh7FFFFFFF || (sa + sb) < -64'sh80000000) begin
          o = m_out;
          v = 1'b1;
        end
`endif
      end
      6'h21: o = a + b;
      6'h22: begin
        o = a - b;
`ifdef ALU_OVERFLOW_TRAP_EN
        if ((sa - sb) > 64'sh7FFFFFFF || (sa - sb) < -64'sh80000000) begin
          o = m_out;
          v = 1'b1;
        end
`endif
      end
      6'h24: o = a & b;
      6'h25: o = a | b;
      6'h2B: o = (a < b) ? 32'd1 : 32'd0;
      6'h10: o = m_hi;
      6'h12: o = m_lo;
      6'h18: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
        o = m_lo;
      end
      6'h19: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
        o = m_lo;
      end
      6'h1A, 6'h1B: begin
        if (b == '0) begin
          m_lo = '1;
          m_hi = a;
        end else if (f == 6'h1A) begin
          m_lo = 32'(sa / sb);
          m_hi = 32'(sa % sb);
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        o = m_lo;
      end
      default: o = '0;
    endcase
    m_out = o;
    q_out.push_back(o);
    q_hi.push_back(m_hi);
    q_lo.push_back(m_lo);
    q_ovf.push_back(v);
    q_nm.push_back(nm);
  endtask

  // Issue one op, then measure latency and cycles with in_ready low
  task automatic issue(input string nm, input logic [5:0] f,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] sh,
                       output int lat, output int busy);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout in_ready=%b want 1", nm, in_ready);
    end
    expect_op(nm, f, a, b, sh);
    funct = f;
    inp1 = a;
    inp2 = b;
    shamt = sh;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    busy = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready === 1'b0) busy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid === 1'b1) begin
      checks++;
      if (q_out.size() == 0) begin
        errors++;
        $display("FAIL spurious_out_valid out=%h want no pulse", out);
      end else begin
        e_o = q_out.pop_front();
        e_h = q_hi.pop_front();
        e_l = q_lo.pop_front();
        e_v = q_ovf.pop_front();
        e_n = q_nm.pop_front();
        if (out !== e_o || hi !== e_h || lo !== e_l) begin
          errors++;
          $display("FAIL %s out=%h hi=%h lo=%h want out=%h hi=%h lo=%h",
                   e_n, out, hi, lo, e_o, e_h, e_l);
        end
`ifdef ALU_OVERFLOW_TRAP_EN
        checks++;
        if (ovf !== e_v) begin
          errors++;
          $display("FAIL %s_ovf got %b want %b", e_n, ovf, e_v);
        end
`endif
      end
    end
  end

  task automatic chk_lat(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic test_reset();
    int lat;
    int busy;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out !== '0 || hi !== '0 || lo !== '0 ||
        in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state out=%h hi=%h lo=%h rdy=%b vld=%b want 0 0 0 1 0",
               out, hi, lo, in_ready, out_valid);
    end
    issue("add_5_7", 6'h20, 32'd5, 32'd7, 5'd0, lat, busy);
    chk_lat("add_latency", lat, 1);
  endtask

  task automatic test_shifts();
    int lat;
    int busy;
    issue("sra", 6'h03, 32'h0, 32'h80000000, 5'd4, lat, busy);
    issue("srl", 6'h02, 32'h0, 32'h80000000, 5'd4, lat, busy);
    issue("sll", 6'h00, 32'h0, 32'h1, 5'd31, lat, busy);
    issue("sltu_1", 6'h2B, 32'h1, 32'hFFFFFFFF, 5'd0, lat, busy);
    issue("sltu_0", 6'h2B, 32'hFFFFFFFF, 32'h1, 5'd0, lat, busy);
    issue("sub", 6'h22, 32'd3, 32'd10, 5'd0, lat, busy);
    issue("unknown", 6'h3F, 32'd3, 32'd10, 5'd0, lat, busy);
    chk_lat("unknown_latency", lat, 1);
  endtask

  task automatic test_back_to_back();
    logic [5:0]   fs[4];
    logic [W-1:0] as[4];
    int n;
    fs = '{6'h21, 6'h24, 6'h25, 6'h22};
    as = '{32'h0F0F1234, 32'hFFFF0000, 32'h00000001, 32'h80000000};
    n = 0;
    for (int i = 0; i < 4; i++) begin
      expect_op("b2b", fs[i], as[i], 32'h00FF00FF, 5'd0);
      funct = fs[i];
      inp1 = as[i];
      inp2 = 32'h00FF00FF;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) n++;
    end
    in_valid = 1'b0;
    chk_lat("b2b_pulses", n, 4);
    @(posedge clk);
    #1;
    chk_lat("b2b_idle_valid", int'(out_valid), 0);
  endtask

  task automatic test_mult();
    int lat;
    int busy;
    issue("mult_m3_7", 6'h18, -32'sd3, 32'd7, 5'd0, lat, busy);
    chk_lat("mult_latency", lat, 33);
    chk_lat("mult_busy_cycles", busy, 32);
    chk_lat("mult_ready_at_done", int'(in_ready), 1);
    issue("mfhi", 6'h10, 32'd0, 32'd0, 5'd0, lat, busy);
    issue("multu_big", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, lat, busy);
    issue("mflo", 6'h12, 32'd0, 32'd0, 5'd0, lat, busy);
  endtask

  task automatic test_div();
    int lat;
    int busy;
    issue("div_m7_2", 6'h1A, -32'sd7, 32'd2, 5'd0, lat, busy);
    chk_lat("div_latency", lat, 33);
    issue("div_7_m2", 6'h1A, 32'd7, -32'sd2, 5'd0, lat, busy);
    issue("divu_big", 6'h1B, 32'hFFFFFFF0, 32'd7, 5'd0, lat, busy);
    issue("divu_by0", 6'h1B, 32'd7, 32'd0, 5'd0, lat, busy);
    chk_lat("div0_latency", lat, 1);
    issue("div_minneg", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 5'd0, lat, busy);
    chk_lat("div_minneg_latency", lat, 33);
  endtask

  task automatic test_busy_ignore();
    int n;
    int k;
    expect_op("multu_busy", 6'h19, 32'd5, 32'd6, 5'd0);
    funct = 6'h19;
    inp1 = 32'd5;
    inp2 = 32'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    funct = 6'h20;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) n++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (out_valid === 1'b1) n++;
    chk_lat("busy_pulses", n, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort();
    int n;
    funct = 6'h19;
    inp1 = 32'hFFFFFFFF;
    inp2 = 32'd2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    m_out = '0;
    checks++;
    if (out_valid !== 1'b0 || hi !== '0 || lo !== '0 ||
        in_ready !== 1'b1 || out !== '0) begin
      errors++;
      $display("FAIL abort_state vld=%b hi=%h lo=%h rdy=%b out=%h want 0 0 0 1 0",
               out_valid, hi, lo, in_ready, out);
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) n++;
    end
    chk_lat("abort_pulses", n, 0);
  endtask

  task automatic test_overflow();
    int lat;
    int busy;
    issue("or_mark", 6'h25, 32'h12340000, 32'h00005678, 5'd0, lat, busy);
    issue("add_ovf", 6'h20, 32'h7FFFFFFF, 32'h1, 5'd0, lat, busy);
    issue("addu_wrap", 6'h21, 32'h7FFFFFFF, 32'h1, 5'd0, lat, busy);
    issue("sub_ovf", 6'h22, 32'h80000000, 32'h1, 5'd0, lat, busy);
    issue("add_ok", 6'h20, 32'hFFFFFFFF, 32'h1, 5'd0, lat, busy);
  endtask

  initial begin
    test_reset();
    test_shifts();
    test_back_to_back();
    test_mult();
    test_div();
    test_busy_ignore();
    test_reset_abort();
    test_overflow();
    repeat (3) @(posedge clk);
    #1;
    chk_lat("scoreboard_left", q_out.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
